// File: rtl/div_unit_if.sv
// Request/response bundle between the EX stage and the multi-cycle divider.
// The EX stage uses the master side; the divider uses the slave side.
interface div_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                      start;
  logic                      signed_div;
  logic                      annul;
  logic [DATA_WIDTH-1:0]     dividend;
  logic [DATA_WIDTH-1:0]     divisor;
  logic [2*DATA_WIDTH-1:0]   result;
  logic                      ready;
  logic                      stall_request;

  modport master (
    output start, signed_div, annul, dividend, divisor,
    input  result, ready, stall_request
  );

  modport slave (
    input  start, signed_div, annul, dividend, divisor,
    output result, ready, stall_request
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// The result is {remainder, quotient}, which feeds the HI/LO write path.
// Signed division runs on magnitudes; the signs are fixed up on the way out.
module div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  div_unit_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, DIV_ZERO, RUN, DONE} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [CNT_W-1:0]        counter;
  logic [DATA_WIDTH-1:0]   rem;
  logic [DATA_WIDTH-1:0]   quo;
  logic [DATA_WIDTH-1:0]   dvs;
  logic                    q_neg;
  logic                    r_neg;
  logic [2*DATA_WIDTH-1:0] result;
  logic                    ready;

  logic [DATA_WIDTH:0]     rem_shift;
  logic [DATA_WIDTH:0]     rem_diff;
  logic [DATA_WIDTH-1:0]   dividend_abs;
  logic [DATA_WIDTH-1:0]   divisor_abs;
  logic [DATA_WIDTH-1:0]   quo_fixed;
  logic [DATA_WIDTH-1:0]   rem_fixed;

  // Operand magnitudes, one trial subtraction step, and the final sign fix.
  always_comb begin
    dividend_abs = (bus.signed_div && bus.dividend[DATA_WIDTH-1]) ? -bus.dividend : bus.dividend;
    divisor_abs  = (bus.signed_div && bus.divisor[DATA_WIDTH-1])  ? -bus.divisor  : bus.divisor;
    rem_shift    = {rem, quo[DATA_WIDTH-1]};
    rem_diff     = rem_shift - {1'b0, dvs};
    quo_fixed    = q_neg ? -quo : quo;
    rem_fixed    = r_neg ? -rem : rem;
  end

  // State register; reset returns to IDLE from anywhere, including mid-division.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; annul beats start and aborts any in-flight work.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start && !bus.annul)
          state_next = (bus.divisor == '0) ? DIV_ZERO : RUN;
      end
      DIV_ZERO: state_next = bus.annul ? IDLE : DONE;
      RUN: begin
        if (bus.annul)               state_next = IDLE;
        else if (counter == CNT_LAST) state_next = DONE;
      end
      DONE: begin
        if (!bus.start || bus.annul) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch operands, iterate one quotient bit per cycle, publish the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      result  <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          if (state_next == RUN) begin
            counter <= '0;
            rem     <= '0;
            quo     <= dividend_abs;
            dvs     <= divisor_abs;
            q_neg   <= bus.signed_div & (bus.dividend[DATA_WIDTH-1] ^ bus.divisor[DATA_WIDTH-1]);
            r_neg   <= bus.signed_div & bus.dividend[DATA_WIDTH-1];
          end
        end
        DIV_ZERO: begin
          if (state_next == DONE) begin
            result <= '0;
            ready  <= 1'b1;
          end
        end
        RUN: begin
          if (state_next == DONE) begin
            result <= {rem_fixed, quo_fixed};
            ready  <= 1'b1;
          end else if (state_next == RUN) begin
            rem     <= rem_diff[DATA_WIDTH] ? rem_shift[DATA_WIDTH-1:0] : rem_diff[DATA_WIDTH-1:0];
            quo     <= {quo[DATA_WIDTH-2:0], ~rem_diff[DATA_WIDTH]};
            counter <= counter + CNT_W'(1);
          end
        end
        DONE: begin
          if (state_next == IDLE) ready <= 1'b0;
        end
        default: ready <= 1'b0;
      endcase
    end
  end

  assign bus.result        = result;
  assign bus.ready         = ready;
  assign bus.stall_request = bus.start & ~ready;

endmodule
